// File: rtl/misr_signature_analyzer.sv
// misr_signature_analyzer
// Output-response compactor for the per-scan BIST path. It folds the CUT
// observation bits into a multiple-input signature register (MISR) while the
// BIST controller is running. It also counts the compacted cycles. On a finish
// request it compares the signature and the count against golden values.
// Optional feature macro: MISR_XMASK_EN adds a data_mask input. Each masked
// bit is forced to 0 before compaction, so unknown CUT outputs are excluded.
module misr_signature_analyzer #(
  parameter int                 WIDTH     = 16,
  parameter int                 IN_WIDTH  = 9,
  parameter logic [WIDTH-1:0]   POLY      = 16'h1021,
  parameter logic [WIDTH-1:0]   SEED      = 16'hFFFF,
  parameter logic [WIDTH-1:0]   GOLDEN    = 16'h0000,
  parameter int                 CNT_W     = 14,
  parameter logic [CNT_W-1:0]   EXP_COUNT = 14'd0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                init,
  input  logic                running,
  input  logic                finish,
  input  logic [IN_WIDTH-1:0] data_in,
`ifdef MISR_XMASK_EN
  input  logic [IN_WIDTH-1:0] data_mask,
`endif
  output logic [WIDTH-1:0]    signature,
  output logic [CNT_W-1:0]    compact_count,
  output logic                done,
  output logic                pass_nfail
);

  typedef enum logic [1:0] {IDLE, ARMED, CHECK, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sig_q, sig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [IN_WIDTH-1:0] data_eff;

  // One MISR step: shift, conditional polynomial feedback, parallel input XOR.
  function automatic logic [WIDTH-1:0] misr_next(input logic [WIDTH-1:0] cur,
                                                 input logic [IN_WIDTH-1:0] din);
    logic [WIDTH-1:0] nxt;
    nxt = cur << 1;
    if (cur[WIDTH-1]) nxt = nxt ^ POLY;
    nxt = nxt ^ WIDTH'(din);
    return nxt;
  endfunction

  // Cycle counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cur);
    return (cur == '1) ? cur : cur + CNT_W'(1);
  endfunction

  // Effective observation bits after optional X-masking.
`ifdef MISR_XMASK_EN
  assign data_eff = data_in & ~data_mask;
`else
  assign data_eff = data_in;
`endif

  // State and datapath registers; async reset restores the seed and clears status.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic: init overrides everything, then finish, then running.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    pass_d  = pass_q;
    if (init) begin
      state_d = ARMED;
      sig_d   = SEED;
      cnt_d   = '0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Waiting for the controller to arm the compactor.
        end
        ARMED: begin
          // A running cycle that coincides with finish is still compacted,
          // so the compare in CHECK sees the updated signature and count.
          if (running) begin
            sig_d = misr_next(sig_q, data_eff);
            cnt_d = sat_inc(cnt_q);
          end
          if (finish) state_d = CHECK;
        end
        CHECK: begin
          pass_d  = (sig_q == GOLDEN) && (cnt_q == EXP_COUNT);
          done_d  = 1'b1;
          state_d = DONE;
        end
        DONE: begin
          // Result is sticky until the next init.
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign signature     = sig_q;
  assign compact_count = cnt_q;
  assign done          = done_q;
  assign pass_nfail    = pass_q;

endmodule
